eth_tx_arbiter: RTL and testbench

Frame-atomic arbiter that shares the single Ethernet frame transmit path (header + payload AXI-Stream into the MII encoder) between N_PORTS requesters. It grants one requester per frame, forwards that requester's header and then its payload until tlast, and re-arbitrates only at frame boundaries. It sits between the per-protocol frame generators and the Ethernet TX encoder.

---
 rtl/eth_tx_arbiter_if.sv | 49 ++++
 rtl/eth_tx_arbiter.sv | 108 ++++++++++
 tb/tb_eth_tx_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_arbiter_if.sv
// Stream bundle for eth_tx_arbiter: N_PORTS requester header/payload streams plus the encoder side.
// slave is the arbiter's view; master is the requesters-plus-encoder view.
interface eth_tx_arbiter_if #(
    parameter int N_PORTS    = 2,
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = 1
);
    logic [N_PORTS-1:0]            s_hdr_valid;
    logic [N_PORTS-1:0]            s_hdr_ready;
    logic [48*N_PORTS-1:0]         s_dest_mac;
    logic [48*N_PORTS-1:0]         s_src_mac;
    logic [16*N_PORTS-1:0]         s_eth_type;
    logic [DATA_WIDTH*N_PORTS-1:0] s_tdata;
    logic [KEEP_WIDTH*N_PORTS-1:0] s_tkeep;
    logic [N_PORTS-1:0]            s_tvalid;
    logic [N_PORTS-1:0]            s_tready;
    logic [N_PORTS-1:0]            s_tlast;
    logic [N_PORTS-1:0]            s_tuser;

    logic                          m_hdr_valid;
    logic                          m_hdr_ready;
    logic [47:0]                   m_dest_mac;
    logic [47:0]                   m_src_mac;
    logic [15:0]                   m_eth_type;
    logic [DATA_WIDTH-1:0]         m_tdata;
    logic [KEEP_WIDTH-1:0]         m_tkeep;
    logic                          m_tvalid;
    logic                          m_tready;
    logic                          m_tlast;
    logic                          m_tuser;

    modport master (
        output s_hdr_valid, s_dest_mac, s_src_mac, s_eth_type,
               s_tdata, s_tkeep, s_tvalid, s_tlast, s_tuser,
               m_hdr_ready, m_tready,
        input  s_hdr_ready, s_tready,
               m_hdr_valid, m_dest_mac, m_src_mac, m_eth_type,
               m_tdata, m_tkeep, m_tvalid, m_tlast, m_tuser
    );

    modport slave (
        input  s_hdr_valid, s_dest_mac, s_src_mac, s_eth_type,
               s_tdata, s_tkeep, s_tvalid, s_tlast, s_tuser,
               m_hdr_ready, m_tready,
        output s_hdr_ready, s_tready,
               m_hdr_valid, m_dest_mac, m_src_mac, m_eth_type,
               m_tdata, m_tkeep, m_tvalid, m_tlast, m_tuser
    );
endinterface

// File: rtl/eth_tx_arbiter.sv
// Frame-atomic N-port arbiter for the Ethernet TX header+payload path; re-arbitrates only after tlast.
// Define ETH_TX_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module eth_tx_arbiter #(
    parameter  int N_PORTS    = 2,
    parameter  int DATA_WIDTH = 8,
    parameter  int KEEP_WIDTH = 1,
    localparam int IDX_W      = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    eth_tx_arbiter_if.slave     bus,
    output logic                grant_valid,
    output logic [IDX_W-1:0]    grant_idx,
    output logic [15:0]         frame_count
);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] pick_idx;
    logic             hdr_fire;
    logic             last_fire;

    // Search upward from rr_ptr with wrap; walking the offsets downward lets the nearest requester win.
    // With fixed priority rr_ptr never leaves 0, so the same search becomes lowest-index-first.
    always_comb begin
        pick_idx = '0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            int j;
            j = int'(rr_ptr) + i;
            if (j >= N_PORTS) j = j - N_PORTS;
            if (bus.s_hdr_valid[j]) pick_idx = IDX_W'(j);
        end
    end

    assign hdr_fire  = (state == HDR) && bus.m_hdr_valid && bus.m_hdr_ready;
    assign last_fire = (state == PAYLOAD) && bus.m_tvalid && bus.m_tready && bus.m_tlast;

    // NOTE: every register is assigned with <= so all of them sample pre-edge values together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            frame_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.s_hdr_valid) begin
                        grant_idx   <= pick_idx;
                        grant_valid <= 1'b1;
                        state       <= HDR;
                    end
                end
                HDR: begin
                    if (hdr_fire) state <= PAYLOAD;
                end
                PAYLOAD: begin
                    if (last_fire) begin
                        frame_count <= frame_count + 16'd1;
`ifdef ETH_TX_ARB_FIXED_PRIO_EN
                        rr_ptr      <= '0;
`else
                        rr_ptr      <= (int'(grant_idx) == N_PORTS - 1) ? '0 : grant_idx + 1'b1;
`endif
                        grant_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data/sideband always follow grant_idx; only valids and readies are gated by state.
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    always_comb begin
        bus.s_hdr_ready = '0;
        bus.s_tready    = '0;
        bus.m_hdr_valid = 1'b0;
        bus.m_tvalid    = 1'b0;
        bus.m_dest_mac  = bus.s_dest_mac[grant_idx*48 +: 48];
        bus.m_src_mac   = bus.s_src_mac[grant_idx*48 +: 48];
        bus.m_eth_type  = bus.s_eth_type[grant_idx*16 +: 16];
        bus.m_tdata     = bus.s_tdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        bus.m_tkeep     = bus.s_tkeep[grant_idx*KEEP_WIDTH +: KEEP_WIDTH];
        bus.m_tlast     = bus.s_tlast[grant_idx];
        bus.m_tuser     = bus.s_tuser[grant_idx];
        case (state)
            HDR: begin
                bus.m_hdr_valid            = bus.s_hdr_valid[grant_idx];
                bus.s_hdr_ready[grant_idx] = bus.m_hdr_ready;
            end
            PAYLOAD: begin
                bus.m_tvalid            = bus.s_tvalid[grant_idx];
                bus.s_tready[grant_idx] = bus.m_tready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Directed bench for eth_tx_arbiter: per-port frame sources, an encoder-side monitor and hand-computed orders.
// Build with ETH_TX_ARB_FIXED_PRIO_EN defined to exercise the fixed-priority variant.
`timescale 1ns/1ps
module tb_eth_tx_arbiter;
    localparam int NP = 2;
    localparam int DW = 8;
    localparam int KW = 1;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    grant_valid;
    logic [$clog2(NP)-1:0]   grant_idx;
    logic [15:0]             frame_count;

    eth_tx_arbiter_if #(.N_PORTS(NP), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) bus ();

    eth_tx_arbiter #(.N_PORTS(NP), .DATA_WIDTH(DW), .KEEP_WIDTH(KW)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit toggle_ready = 1'b0;

    // Source side
    int src_len_q  [NP][$];
    bit src_user_q [NP][$];
    bit busy [NP];
    bit hdr_done [NP];
    bit fuser [NP];
    int flen [NP];
    int beat [NP];
    int fnum [NP];
    int rise_cyc [NP];
    bit hdr_fire [NP];
    bit pay_fire [NP];

    // Monitor side
    int exp_order [$];
    int exp_len_q  [NP][$];
    bit exp_user_q [NP][$];
    bit in_frame   = 1'b0;
    bit gv_pending = 1'b0;
    bit cur_user;
    int cur_p, cur_len, rx_beat, data_errs, first_cyc;
    int rx_fnum [NP];
    int done_frames = 0;
    int viol = 0;
    int last_lat = 0;
    int last_span = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] beat_data(input int p, input int f, input int b);
        return 8'((p << 7) | ((f * 13 + b) & 'h7f));
    endfunction

    function automatic logic [111:0] hdr_model(input int p, input int f);
        logic [47:0] d;
        logic [47:0] s;
        logic [15:0] t;
        d = 48'h0200_0000_0000 | 48'(p * 256 + f);
        s = 48'h0A0B_0C0D_0000 + 48'(p);
        t = 16'h0800 + 16'(f);
        return {d, s, t};
    endfunction

    task automatic push_frame(input int p, input int len, input bit user);
        src_len_q[p].push_back(len);
        src_user_q[p].push_back(user);
        exp_len_q[p].push_back(len);
        exp_user_q[p].push_back(user);
    endtask

    // Encoder-side observer, called at each negedge while every signal is settled.
    task automatic sample();
        if (gv_pending) begin
            check("grant_valid_fall", grant_valid, 1'b0);
            gv_pending = 1'b0;
        end
        if (rst) begin
            in_frame = 1'b0;
            done_frames = 0;
            exp_order.delete();
            for (int p = 0; p < NP; p++) begin
                exp_len_q[p].delete();
                exp_user_q[p].delete();
                rx_fnum[p]  = 0;
                hdr_fire[p] = 1'b0;
                pay_fire[p] = 1'b0;
            end
            return;
        end
        for (int p = 0; p < NP; p++) begin
            hdr_fire[p] = bus.s_hdr_valid[p] & bus.s_hdr_ready[p];
            pay_fire[p] = bus.s_tvalid[p] & bus.s_tready[p];
            if (bus.s_hdr_ready[p] && (in_frame || exp_order.size() == 0 || exp_order[0] != p)) viol++;
            if (bus.s_tready[p] && !(in_frame && cur_p == p)) viol++;
        end
        if (bus.m_tvalid && !in_frame) viol++;
        if (bus.m_hdr_valid && in_frame) viol++;

        if (bus.m_hdr_valid && bus.m_hdr_ready) begin
            check("order_avail", exp_order.size() != 0, 1'b1);
            if (exp_order.size() != 0 && exp_len_q[exp_order[0]].size() != 0) begin
                cur_p = exp_order.pop_front();
                check("grant_idx", grant_idx, cur_p);
                check("hdr_fields", {bus.m_dest_mac, bus.m_src_mac, bus.m_eth_type},
                      hdr_model(cur_p, rx_fnum[cur_p]));
                cur_len   = exp_len_q[cur_p].pop_front();
                cur_user  = exp_user_q[cur_p].pop_front();
                last_lat  = cyc - rise_cyc[cur_p];
                in_frame  = 1'b1;
                rx_beat   = 0;
                data_errs = 0;
            end
        end else if (in_frame && bus.m_tvalid && bus.m_tready) begin
            if (rx_beat == 0) first_cyc = cyc;
            if (bus.m_tdata !== beat_data(cur_p, rx_fnum[cur_p], rx_beat)) data_errs++;
            if (bus.m_tkeep !== 1'b1) data_errs++;
            if (bus.m_tlast !== (rx_beat == cur_len - 1)) data_errs++;
            if (!bus.m_tlast && bus.m_tuser !== 1'b0) data_errs++;
            rx_beat++;
            if (bus.m_tlast) begin
                check("frame_data", data_errs, 0);
                check("frame_len", rx_beat, cur_len);
                check("frame_tuser", bus.m_tuser, cur_user);
                check("grant_valid_busy", grant_valid, 1'b1);
                last_span = cyc - first_cyc;
                rx_fnum[cur_p]++;
                done_frames++;
                in_frame   = 1'b0;
                gv_pending = 1'b1;
            end
        end
    endtask

    // Requester sources: header and payload beat 0 are presented together, payload waits for the grant.
    task automatic drive();
        logic [111:0] h;
        for (int p = 0; p < NP; p++) begin
            if (rst) begin
                busy[p] = 1'b0;
                hdr_done[p] = 1'b0;
                fnum[p] = 0;
                src_len_q[p].delete();
                src_user_q[p].delete();
            end else begin
                if (hdr_fire[p]) hdr_done[p] = 1'b1;
                if (pay_fire[p]) begin
                    if (beat[p] == flen[p] - 1) begin
                        busy[p] = 1'b0;
                        fnum[p]++;
                    end else begin
                        beat[p]++;
                    end
                end
                if (!busy[p] && src_len_q[p].size() != 0) begin
                    flen[p]     = src_len_q[p].pop_front();
                    fuser[p]    = src_user_q[p].pop_front();
                    busy[p]     = 1'b1;
                    hdr_done[p] = 1'b0;
                    beat[p]     = 0;
                    rise_cyc[p] = cyc;
                end
            end
            h = hdr_model(p, fnum[p]);
            bus.s_hdr_valid[p]          = busy[p] && !hdr_done[p];
            bus.s_tvalid[p]             = busy[p];
            bus.s_tdata[p*DW +: DW]     = beat_data(p, fnum[p], beat[p]);
            bus.s_tkeep[p*KW +: KW]     = {KW{busy[p]}};
            bus.s_tlast[p]              = busy[p] && (beat[p] == flen[p] - 1);
            bus.s_tuser[p]              = busy[p] && fuser[p] && (beat[p] == flen[p] - 1);
            bus.s_dest_mac[p*48 +: 48]  = h[111:64];
            bus.s_src_mac[p*48 +: 48]   = h[63:16];
            bus.s_eth_type[p*16 +: 16]  = h[15:0];
        end
        bus.m_hdr_ready = 1'b1;
        bus.m_tready    = toggle_ready ? cyc[0] : 1'b1;
    endtask

    initial begin
        bus.s_hdr_valid = '0;
        bus.s_dest_mac  = '0;
        bus.s_src_mac   = '0;
        bus.s_eth_type  = '0;
        bus.s_tdata     = '0;
        bus.s_tkeep     = '0;
        bus.s_tvalid    = '0;
        bus.s_tlast     = '0;
        bus.s_tuser     = '0;
        bus.m_hdr_ready = 1'b0;
        bus.m_tready    = 1'b0;
        forever begin
            @(negedge clk);
            sample();
            @(posedge clk);
            cyc++;
            #1;
            drive();
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget, input string tag);
        int i;
        i = 0;
        while (done_frames < n && i < budget) begin
            tick();
            i++;
        end
        check(tag, done_frames, n);
        repeat (3) tick();
    endtask

    task automatic wait_beats(input int n, input int budget, input string tag);
        int i;
        i = 0;
        while (!(in_frame && rx_beat >= n) && i < budget) begin
            tick();
            i++;
        end
        check(tag, in_frame && rx_beat >= n, 1'b1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check(tag, {bus.s_hdr_ready, bus.s_tready, bus.m_hdr_valid, bus.m_tvalid}, '0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        @(negedge clk);
        check("rst_grant_valid", grant_valid, 1'b0);
        check("rst_grant_idx", grant_idx, 0);
        check("rst_frame_count", frame_count, 16'd0);
        check_idle_outputs("rst_outputs");
        tick();
        rst = 1'b0;

        // Single port, 60-byte frame, encoder always ready
        push_frame(0, 60, 1'b0);
        exp_order.push_back(0);
        wait_frames(1, 300, "t1_done");
        check("t1_frame_count", frame_count, 16'd1);
        check("t1_hdr_latency", last_lat, 1);
        check("t1_payload_span", last_span, 59);

        // Both ports, 3 frames each
        do_reset();
        for (int k = 0; k < 3; k++) begin
            push_frame(0, 8, 1'b0);
            push_frame(1, 5, 1'b0);
        end
`ifdef ETH_TX_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 1, 1, 1};
`else
        exp_order = '{0, 1, 0, 1, 0, 1};
`endif
        wait_frames(6, 300, "t2_done");
        check("t2_frame_count", frame_count, 16'd6);
        check("t2_hold_off", viol, 0);

        // Port 1 arrives mid-frame while m_tready toggles
        do_reset();
        toggle_ready = 1'b1;
        push_frame(0, 30, 1'b0);
        exp_order = '{0, 1};
        wait_beats(10, 200, "t3_mid_frame");
        push_frame(1, 6, 1'b0);
        wait_frames(2, 300, "t3_done");
        check("t3_frame_count", frame_count, 16'd2);
        check("t3_hold_off", viol, 0);
        toggle_ready = 1'b0;

        // Reset at beat 20 of a 64-byte frame on port 1
        push_frame(1, 64, 1'b0);
        exp_order.push_back(1);
        wait_beats(20, 200, "t4_beat20");
        check("t4_pre_grant_idx", grant_idx, 1);
        rst = 1'b1;
        tick();
        @(negedge clk);
        check("t4_grant_valid", grant_valid, 1'b0);
        check("t4_grant_idx", grant_idx, 0);
        check("t4_frame_count", frame_count, 16'd0);
        check_idle_outputs("t4_outputs");
        tick();
        rst = 1'b0;
        push_frame(1, 64, 1'b0);
        exp_order.push_back(1);
        wait_frames(1, 300, "t4_done");
        check("t4_frame_count_after", frame_count, 16'd1);

        // Aborted frame (tuser on tlast) still counts and rotates
        do_reset();
        push_frame(0, 10, 1'b1);
        push_frame(0, 4, 1'b0);
        push_frame(1, 7, 1'b0);
`ifdef ETH_TX_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 1};
`else
        exp_order = '{0, 1, 0};
`endif
        wait_frames(3, 300, "t5_done");
        check("t5_frame_count", frame_count, 16'd3);

        // Continuous requests from both ports
        do_reset();
        for (int k = 0; k < 3; k++) begin
            push_frame(0, 5, 1'b0);
            push_frame(1, 5, 1'b0);
        end
`ifdef ETH_TX_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 1, 1, 1};
`else
        exp_order = '{0, 1, 0, 1, 0, 1};
`endif
        wait_frames(6, 300, "t6_done");
        check("t6_frame_count", frame_count, 16'd6);
        check("t6_hold_off", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
